// File: rtl/mcs4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcs4_pkg
// Purpose  : Shared constants and types for the MCS-4 instruction-cycle
//            sequencer: phase period, phase-low decode points, subcycle and
//            FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package mcs4_pkg;

  // Phase counter: 7 clk_i per two-phase clock period.
  localparam int                 PHASE_W      = 3;
  localparam int                 PHASE_PERIOD = 7;
  localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(PHASE_PERIOD - 1);

  // Phase counts during which each clock phase is driven low.
  localparam logic [PHASE_W-1:0] PHI1_LOW_A = 3'd0;
  localparam logic [PHASE_W-1:0] PHI1_LOW_B = 3'd1;
  localparam logic [PHASE_W-1:0] PHI2_LOW_A = 3'd4;
  localparam logic [PHASE_W-1:0] PHI2_LOW_B = 3'd5;

  // Instruction-cycle position.
  typedef enum logic [2:0] {
    SC_A1 = 3'd0,
    SC_A2 = 3'd1,
    SC_A3 = 3'd2,
    SC_M1 = 3'd3,
    SC_M2 = 3'd4,
    SC_X1 = 3'd5,
    SC_X2 = 3'd6,
    SC_X3 = 3'd7
  } subcycle_e;

  // Sequencer control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/mcs4_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : mcs4_phase_gen
// Purpose  : Enable-gated phase counter (0..6) with registered active-low
//            PHI1/PHI2 outputs and a wrap strobe for the subcycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module mcs4_phase_gen
  import mcs4_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,          // currently inside a cycle
  input  logic               active_next_i, // still inside a cycle after this edge
  output logic [PHASE_W-1:0] phase_o,
  output logic [PHASE_W-1:0] phase_next_o,
  output logic               wrap_o,
  output logic               phi1_o,
  output logic               phi2_o
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               phi1_q, phi1_d;
  logic               phi2_q, phi2_d;

  // Next phase count and clock levels; a fresh cycle or an idle sequencer
  // always lands on phase 0 so the phases are decoded from the next count.
  always_comb begin
    phase_d = '0;
    if (en_i && active_next_i && (phase_q != PHASE_LAST)) begin
      phase_d = phase_q + PHASE_W'(1);
    end
    phi1_d = !(active_next_i && ((phase_d == PHI1_LOW_A) || (phase_d == PHI1_LOW_B)));
    phi2_d = !(active_next_i && ((phase_d == PHI2_LOW_A) || (phase_d == PHI2_LOW_B)));
  end

  // Phase state and clock output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= '0;
      phi1_q  <= 1'b1;
      phi2_q  <= 1'b1;
    end else begin
      phase_q <= phase_d;
      phi1_q  <= phi1_d;
      phi2_q  <= phi2_d;
    end
  end

  assign phase_o      = phase_q;
  assign phase_next_o = phase_d;
  assign wrap_o       = en_i && (phase_q == PHASE_LAST);
  assign phi1_o       = phi1_q;
  assign phi2_o       = phi2_q;

endmodule
`default_nettype wire

// File: rtl/mcs4_cycle_seq.sv
`default_nettype none
// ============================================================================
// Module   : mcs4_cycle_seq
// Purpose  : MCS-4 instruction-cycle sequencer. Produces PHI1/PHI2, the
//            A1..X3 subcycle, SYNC, a cycle-done strobe and a completed-cycle
//            counter, gated by run/halt and single-step control.
// Options  : MCS4_CYCLE_SEQ_STEP_EN - enables the single-step state; when
//            undefined step_i is accepted but has no effect.
// Revision : 1.0 - initial release
// ============================================================================
module mcs4_cycle_seq
  import mcs4_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic        step_i,
  output logic        PHI1_o,
  output logic        PHI2_o,
  output logic        SYNC_o,
  output logic [2:0]  subcycle_o,
  output logic        cycle_done_o,
  output logic        running_o,
  output logic [15:0] cycle_cnt_o
);

  seq_state_e         state_q, state_d;
  subcycle_e          sub_q, sub_d;
  logic               sync_q, sync_d;
  logic               done_q, done_d;
  logic               running_q, running_d;
  logic [15:0]        cnt_q, cnt_d;

  logic               active_q, active_d;
  logic               cycle_end;
  logic               wrap;
  logic [PHASE_W-1:0] phase, phase_next;

`ifndef MCS4_CYCLE_SEQ_STEP_EN
  logic unused_step;
  assign unused_step = step_i;
`endif

  assign active_q  = (state_q != ST_IDLE);
  assign cycle_end = active_q && (phase == PHASE_LAST) && (sub_q == SC_X3);

  mcs4_phase_gen u_phase_gen (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (active_q),
    .active_next_i (active_d),
    .phase_o       (phase),
    .phase_next_o  (phase_next),
    .wrap_o        (wrap),
    .phi1_o        (PHI1_o),
    .phi2_o        (PHI2_o)
  );

  // Next-state logic plus every output computed from the post-edge values so
  // that all outputs leave the block straight from flops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run_i) begin
          state_d = ST_RUN;
`ifdef MCS4_CYCLE_SEQ_STEP_EN
        end else if (step_i) begin
          state_d = ST_STEP;
`endif
        end
      end
      ST_RUN: begin
        if (!run_i) state_d = cycle_end ? ST_IDLE : ST_FINISH;
      end
`ifdef MCS4_CYCLE_SEQ_STEP_EN
      ST_STEP: begin
        if (run_i)          state_d = ST_RUN;
        else if (cycle_end) state_d = ST_IDLE;
      end
`endif
      ST_FINISH: begin
        if (run_i)          state_d = ST_RUN;
        else if (cycle_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    active_d = (state_d != ST_IDLE);

    sub_d = SC_A1;
    if (active_q && active_d) begin
      sub_d = wrap ? subcycle_e'(sub_q + 3'd1) : sub_q;
    end

    running_d = active_d;
    sync_d    = !(active_d && (sub_d == SC_X3));
    done_d    = active_d && (phase_next == PHASE_LAST) && (sub_d == SC_X3);
    cnt_d     = done_d ? (cnt_q + 16'd1) : cnt_q;
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      sub_q     <= SC_A1;
      sync_q    <= 1'b1;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      sync_q    <= sync_d;
      done_q    <= done_d;
      running_q <= running_d;
      cnt_q     <= cnt_d;
    end
  end

  assign SYNC_o       = sync_q;
  assign subcycle_o   = sub_q;
  assign cycle_done_o = done_q;
  assign running_o    = running_q;
  assign cycle_cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mcs4_cycle_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcs4_cycle_seq
// Purpose  : Self-checking bench for mcs4_cycle_seq. A reference model tracks
//            only "inside a cycle" and the clk position 0..55 in that cycle;
//            all expected pin values are derived from that position.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcs4_cycle_seq;

`ifdef MCS4_CYCLE_SEQ_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        run_i = 1'b0;
  logic        step_i = 1'b0;
  logic        PHI1_o, PHI2_o, SYNC_o, cycle_done_o, running_o;
  logic [2:0]  subcycle_o;
  logic [15:0] cycle_cnt_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit          m_act = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_cnt = 16'd0;

  mcs4_cycle_seq dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .run_i        (run_i),
    .step_i       (step_i),
    .PHI1_o       (PHI1_o),
    .PHI2_o       (PHI2_o),
    .SYNC_o       (SYNC_o),
    .subcycle_o   (subcycle_o),
    .cycle_done_o (cycle_done_o),
    .running_o    (running_o),
    .cycle_cnt_o  (cycle_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against values derived from the model position.
  task automatic check_all();
    int  ph;
    int  sc;
    ph = m_pos % 7;
    sc = m_pos / 7;
    check("phi1",    16'(PHI1_o),       16'(!(m_act && (ph == 0 || ph == 1))));
    check("phi2",    16'(PHI2_o),       16'(!(m_act && (ph == 4 || ph == 5))));
    check("sync",    16'(SYNC_o),       16'(!(m_act && sc == 7)));
    check("sub",     16'(subcycle_o),   m_act ? 16'(sc) : 16'd0);
    check("done",    16'(cycle_done_o), 16'(m_act && m_pos == 55));
    check("running", 16'(running_o),    16'(m_act));
    check("cnt",     cycle_cnt_o,       m_cnt);
  endtask

  // One clk_i: drive inputs, advance model at the edge, check 1 time unit later.
  task automatic tick(input bit run, input bit step);
    run_i  = run;
    step_i = step;
    @(posedge clk_i);
    if (!rst_i) begin
      if (m_act) begin
        if (m_pos == 55) begin
          if (run) m_pos = 0;
          else     m_act = 1'b0;
        end else begin
          m_pos++;
        end
      end else if (run || (STEP_EN && step)) begin
        m_act = 1'b1;
        m_pos = 0;
      end
      if (m_act && m_pos == 55) m_cnt++;
    end
    #1;
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && m_act; i++) tick(1'b0, 1'b0);
    check("drain_idle", 16'(running_o), 16'd0);
  endtask

  initial begin
    // Reset values.
    rst_i = 1'b1;
    #12;
    check_all();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Free run for two full cycles.
    for (int i = 0; i < 112; i++) tick(1'b1, 1'b0);
    check("two_cycles_cnt", cycle_cnt_o, 16'd2);

    // Drop run at clk 20 of the next cycle; cycle must still complete.
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b0);
    check("finish_halted", 16'({PHI1_o, PHI2_o, SYNC_o}), 16'h7);
    check("finish_cnt", cycle_cnt_o, 16'd3);

    // Single step from idle (ignored when the step feature is absent).
    tick(1'b0, 1'b1);
    for (int i = 0; i < 60; i++) tick(1'b0, 1'b0);
    check("step_cnt", cycle_cnt_o, STEP_EN ? 16'd4 : 16'd3);

    // Step pulses during free run have no effect.
    for (int i = 0; i < 70; i++) tick(1'b1, (i % 9) == 3);
    // run 1->0->1 inside one cycle, then let it continue seamlessly.
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < 80; i++) tick(1'b1, 1'b0);

    // Asynchronous reset in the middle of M1.
    while (!(m_act && m_pos == 23)) tick(1'b1, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    m_act = 1'b0;
    m_pos = 0;
    m_cnt = 16'd0;
    check_all();
    tick(1'b0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick(1'b0, 1'b0);

    // Randomized run/step activity.
    for (int seg = 0; seg < 24; seg++) begin
      bit run;
      int len;
      run = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 80);
      for (int i = 0; i < len; i++) tick(run, ($urandom_range(0, 7) == 0));
    end
    drain();

    // Counter wrap: preload near the top, then run two cycles.
    @(negedge clk_i);
    force dut.cnt_q = 16'hFFFE;
    @(posedge clk_i);
    #1;
    release dut.cnt_q;
    m_cnt = 16'hFFFE;
    check("preload", cycle_cnt_o, 16'hFFFE);
    for (int i = 0; i < 56; i++) tick(1'b1, 1'b0);
    check("pre_wrap", cycle_cnt_o, 16'hFFFF);
    for (int i = 0; i < 56; i++) tick(1'b1, 1'b0);
    check("wrap", cycle_cnt_o, 16'h0000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
